gate_sweep_ctrl: RTL and testbench

Self-test sequencer for the small 3-input switch-level gate cells (OR3/AND3/NOR3 style pmos/nmos networks). On a start request it steps the gate-under-test inputs through all 8 combinations and holds each vector for a programmable settle time. It samples the gate output and compares it against an expected truth table, then reports pass/fail, an error count, the first failing vector and a per-vector fail map. It sits between the board-level control (button/LED logic) and the gate instance, replacing the simulation-only sweep loop with synthesizable sequencing.

---
 rtl/gate_sweep_ctrl.sv | 141 ++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: self-test sequencer that sweeps a 3-input gate through all 8 input
// vectors, holds each for SETTLE+1 cycles, samples y and checks it against a truth table.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              sweep request, accepted in IDLE or DONE
//   tt[7:0]            expected truth table (bit i = expected y for x = i), captured on accept
//   y                  gate-under-test output (not synchronized; settle window must cover it)
//   x[2:0]             gate-under-test input vector
//   busy, done         sweep in progress / one-cycle end-of-sweep pulse
//   pass, err_cnt,     results of the last sweep, held until next accept or rst
//   fail_seen, first_fail, fail_map, aborted
// Optional feature: define SWEEP_STOPFAIL_EN to end the sweep on the first mismatch.
module gate_sweep_ctrl #(
    parameter int SETTLE = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tt,
    input  logic       y,
    output logic [2:0] x,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic       fail_seen,
    output logic [2:0] first_fail,
    output logic [7:0] fail_map,
    output logic       aborted
);
    localparam logic [7:0] SETTLE_V = 8'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] tick_q, tick_d;
    logic [7:0] tt_q, tt_d;
    logic       pass_q, pass_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic       fail_seen_q, fail_seen_d;
    logic [2:0] first_fail_q, first_fail_d;
    logic [7:0] fail_map_q, fail_map_d;
    logic       aborted_q, aborted_d;
    logic       accept, sample, mism, stop, last;

    assign accept = start && (state_q != RUN);
    assign sample = (state_q == RUN) && (tick_q == 8'd0);
    assign mism   = sample && (y != tt_q[idx_q]);
`ifdef SWEEP_STOPFAIL_EN
    assign stop   = mism;
`else
    assign stop   = 1'b0;
`endif
    assign last   = sample && ((idx_q == 3'd7) || stop);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = accept ? RUN : (state_q == RUN) ? (last ? DONE : RUN) : IDLE;
    end

    always_comb begin
        x    = (state_q == RUN) ? idx_q : 3'd0;
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        idx_d        = idx_q;
        tick_d       = tick_q;
        tt_d         = tt_q;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
        fail_map_d   = fail_map_q;
        aborted_d    = aborted_q;
        if (accept) begin
            idx_d        = 3'd0;
            tick_d       = SETTLE_V;
            tt_d         = tt;
            pass_d       = 1'b0;
            err_cnt_d    = 4'd0;
            fail_seen_d  = 1'b0;
            first_fail_d = 3'd0;
            fail_map_d   = 8'd0;
            aborted_d    = 1'b0;
        end else if (sample) begin
            err_cnt_d         = err_cnt_q + 4'(mism);
            fail_map_d[idx_q] = fail_map_q[idx_q] | mism;
            if (mism && !fail_seen_q) begin
                fail_seen_d  = 1'b1;
                first_fail_d = idx_q;
            end
            if (last) begin
                pass_d    = (err_cnt_d == 4'd0);
                aborted_d = stop;
            end else begin
                idx_d  = idx_q + 3'd1;
                tick_d = SETTLE_V;
            end
        end else if (state_q == RUN) begin
            tick_d = tick_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= 3'd0;
            tick_q       <= 8'd0;
            tt_q         <= 8'd0;
            pass_q       <= 1'b0;
            err_cnt_q    <= 4'd0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= 3'd0;
            fail_map_q   <= 8'd0;
            aborted_q    <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            tick_q       <= tick_d;
            tt_q         <= tt_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
            fail_map_q   <= fail_map_d;
            aborted_q    <= aborted_d;
        end
    end

    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign fail_seen  = fail_seen_q;
    assign first_fail = first_fail_q;
    assign fail_map   = fail_map_q;
    assign aborted    = aborted_q;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: directed self-checking bench for gate_sweep_ctrl with an OR3 gate model.
module tb_gate_sweep_ctrl;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, stuck = 1'b0;
    logic [7:0] tt = 8'hFE;
    logic       y;
    logic [2:0] x, first_fail;
    logic       busy, done, pass, fail_seen, aborted;
    logic [3:0] err_cnt;
    logic [7:0] fail_map;
    int         n_chk = 0, n_fail = 0;

`ifdef SWEEP_STOPFAIL_EN
    localparam int         DC     = 12;
    localparam logic [3:0] ST_ERR = 4'd1;
    localparam logic [7:0] ST_MAP = 8'h02;
    localparam logic       ST_AB  = 1'b1;
`else
    localparam int         DC     = 48;
    localparam logic [3:0] ST_ERR = 4'd7;
    localparam logic [7:0] ST_MAP = 8'hFE;
    localparam logic       ST_AB  = 1'b0;
`endif

    always #5 clk = ~clk;
    assign y = stuck ? 1'b0 : |x;

    gate_sweep_ctrl #(.SETTLE(5)) dut (
        .clk(clk), .rst(rst), .start(start), .tt(tt), .y(y), .x(x), .busy(busy),
        .done(done), .pass(pass), .err_cnt(err_cnt), .fail_seen(fail_seen),
        .first_fail(first_fail), .fail_map(fail_map), .aborted(aborted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_chk++;
        if ({x, busy, done, pass, err_cnt, fail_seen, first_fail, fail_map, aborted} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset: got x=%0d busy=%b done=%b pass=%b err=%0d seen=%b ff=%0d map=%h ab=%b, expected all 0",
                     x, busy, done, pass, err_cnt, fail_seen, first_fail, fail_map, aborted);
        end
        rst = 1'b0;
        step();
        n_chk++;
        if ({x, busy, done} !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got x=%0d busy=%b done=%b, expected 0/0/0", x, busy, done);
        end
    endtask

    task automatic test_or3_pass();
        logic [2:0] ex;
        stuck = 1'b0;
        tt = 8'hFE;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c <= 49; c++) begin
            ex = (c < 48) ? 3'(c / 6) : 3'd0;
            n_chk++;
            if ({x, busy, done} !== {ex, c < 48, c == 48}) begin
                n_fail++;
                $display("FAIL or3_seq c=%0d: got x=%0d busy=%b done=%b, expected x=%0d busy=%b done=%b",
                         c, x, busy, done, ex, c < 48, c == 48);
            end
            if (c >= 48) begin
                n_chk++;
                if ({pass, err_cnt, fail_seen, first_fail, fail_map, aborted} !== {1'b1, 4'd0, 1'b0, 3'd0, 8'h00, 1'b0}) begin
                    n_fail++;
                    $display("FAIL or3_result c=%0d: got pass=%b err=%0d seen=%b ff=%0d map=%h ab=%b, expected 1/0/0/0/00/0",
                             c, pass, err_cnt, fail_seen, first_fail, fail_map, aborted);
                end
            end
            if (c < 49) step();
        end
    endtask

    task automatic test_stuck0();
        logic [2:0] ex;
        stuck = 1'b1;
        tt = 8'hFE;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c <= DC + 1; c++) begin
            ex = (c < DC) ? 3'(c / 6) : 3'd0;
            n_chk++;
            if ({x, busy, done} !== {ex, c < DC, c == DC}) begin
                n_fail++;
                $display("FAIL stuck_seq c=%0d: got x=%0d busy=%b done=%b, expected x=%0d busy=%b done=%b",
                         c, x, busy, done, ex, c < DC, c == DC);
            end
            if (c >= DC) begin
                n_chk++;
                if ({pass, err_cnt, fail_seen, first_fail, fail_map, aborted} !== {1'b0, ST_ERR, 1'b1, 3'd1, ST_MAP, ST_AB}) begin
                    n_fail++;
                    $display("FAIL stuck_result c=%0d: got pass=%b err=%0d seen=%b ff=%0d map=%h ab=%b, expected 0/%0d/1/1/%h/%b",
                             c, pass, err_cnt, fail_seen, first_fail, fail_map, aborted, ST_ERR, ST_MAP, ST_AB);
                end
            end
            if (c < DC + 1) step();
        end
        stuck = 1'b0;
    endtask

    task automatic test_start_ignored();
        logic [2:0] ex;
        stuck = 1'b0;
        tt = 8'hFE;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c <= 49; c++) begin
            ex = (c < 48) ? 3'(c / 6) : 3'd0;
            n_chk++;
            if ({x, busy, done} !== {ex, c < 48, c == 48}) begin
                n_fail++;
                $display("FAIL ignore_seq c=%0d: got x=%0d busy=%b done=%b, expected x=%0d busy=%b done=%b",
                         c, x, busy, done, ex, c < 48, c == 48);
            end
            if (c == 48) begin
                n_chk++;
                if ({pass, err_cnt, fail_map} !== {1'b1, 4'd0, 8'h00}) begin
                    n_fail++;
                    $display("FAIL ignore_result: got pass=%b err=%0d map=%h, expected 1/0/00", pass, err_cnt, fail_map);
                end
            end
            if (c == 20) begin
                start = 1'b1;
                tt = 8'h01;
            end
            if (c == 21) start = 1'b0;
            if (c < 49) step();
        end
        tt = 8'hFE;
    endtask

    task automatic test_reset_mid();
        stuck = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 19; c++) step();
        rst = 1'b1;
        step();
        n_chk++;
        if ({x, busy, done, pass, err_cnt, fail_seen, first_fail, fail_map, aborted} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got x=%0d busy=%b done=%b pass=%b err=%0d seen=%b ff=%0d map=%h ab=%b, expected all 0",
                     x, busy, done, pass, err_cnt, fail_seen, first_fail, fail_map, aborted);
        end
        rst = 1'b0;
        stuck = 1'b0;
        step();
        n_chk++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got busy=%b done=%b, expected 0/0", busy, done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c <= 48; c++) begin
            n_chk++;
            if ({busy, done} !== {c < 48, c == 48}) begin
                n_fail++;
                $display("FAIL reset_mid_resweep c=%0d: got busy=%b done=%b, expected %b/%b", c, busy, done, c < 48, c == 48);
            end
            if (c < 48) step();
        end
        n_chk++;
        if ({pass, err_cnt, fail_seen, fail_map} !== {1'b1, 4'd0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid_result: got pass=%b err=%0d seen=%b map=%h, expected 1/0/0/00", pass, err_cnt, fail_seen, fail_map);
        end
        step();
    endtask

    task automatic test_back_to_back();
        stuck = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < DC; c++) step();
        n_chk++;
        if ({done, err_cnt, fail_map} !== {1'b1, ST_ERR, ST_MAP}) begin
            n_fail++;
            $display("FAIL b2b_first_done: got done=%b err=%0d map=%h, expected 1/%0d/%h", done, err_cnt, fail_map, ST_ERR, ST_MAP);
        end
        start = 1'b1;
        stuck = 1'b0;
        step();
        start = 1'b0;
        n_chk++;
        if ({x, busy, done, pass, err_cnt, fail_seen, fail_map, aborted} !== {3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_accept: got x=%0d busy=%b done=%b pass=%b err=%0d seen=%b map=%h ab=%b, expected 0/1/0/0/0/0/00/0",
                     x, busy, done, pass, err_cnt, fail_seen, fail_map, aborted);
        end
        for (int c = 1; c <= 48; c++) begin
            step();
            n_chk++;
            if ({busy, done} !== {c < 48, c == 48}) begin
                n_fail++;
                $display("FAIL b2b_second c=%0d: got busy=%b done=%b, expected %b/%b", c, busy, done, c < 48, c == 48);
            end
        end
        n_chk++;
        if ({pass, err_cnt, fail_map} !== {1'b1, 4'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL b2b_result: got pass=%b err=%0d map=%h, expected 1/0/00", pass, err_cnt, fail_map);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_or3_pass();
        test_stuck0();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
